cam_i2c_write_sequencer: RTL
============================

Name: cam_i2c_write_sequencer

Overview:
Parametrised successor to the camera register-write table. Accepts one camera command per valid/ready handshake. Each configuration command expands into a sequence of 3-byte sensor register writes (reg addr, data hi, data lo), streamed to the camera I2C master over a byte valid/ready interface with a programmable inter-write gap. Trigger commands and interface-config fields go directly to the camera interface. Supports NUM_CAMS cameras instead of a fixed pair.

Parameters:
NUM_CAMS, 2, number of cameras addressed; CAM_W = max(1, clog2(NUM_CAMS)) is a localparam
IDX_W, 16, trigger index width
TS_W, 28, timestamp width; must satisfy CAM_W+IDX_W+TS_W <= 64
GAP_CYCLES, 4, idle cycles between consecutive register writes (0 = back-to-back)

Ports:
sysClk  in  1  system clock
sysRst_n  in  1  asynchronous active-low reset
cmd_op  in  8  command opcode
cmd_cam  in  CAM_W  target camera for config ops
cmd_data  in  64  command payload
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
i2c_byte  out  8  byte to I2C master
i2c_valid  out  1  byte valid
i2c_ready  in  1  master accepts byte
i2c_first  out  1  byte is register-address byte (start of write)
i2c_last  out  1  byte is data-lo byte (end of write)
cam_sel  out  CAM_W  camera targeted by current sequence/trigger
cfg_compression  out  2  latched compression mode
cfg_rgb  out  1  latched RGB select
cfg_valid  out  1  1-cycle pulse when cfg_* are updated
trigger  out  1  1-cycle trigger pulse
trigger_index  out  IDX_W  latched trigger index
timestamp  out  TS_W  latched timestamp
done  out  1  1-cycle pulse at command completion
err  out  1  1-cycle pulse on unknown opcode

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all outputs 0 except cmd_ready=1. State=IDLE. Counters cleared. Reset mid-sequence drops any in-flight byte; no done pulse is issued.
- Accept: cmd_valid&&cmd_ready at edge N. Latch op/cam/data. cmd_ready=0 from N+1 until return to IDLE. cmd_valid while busy is ignored.
- Opcode 0x01 (trigger): at N+1, trigger=1 and done=1. cam_sel=data[CAM_W-1:0], trigger_index=data[CAM_W+IDX_W-1:CAM_W], timestamp=next TS_W bits. No I2C bytes. Return to IDLE.
- Opcode 0x03 (exposure/binning/blanking, 7 writes): at N+1, cfg_valid=1, cfg_compression=data[1:0], cfg_rgb=data[2]. Writes in order:
  0x08:{00,{4'h0,d[22:19]}}; 0x09:{d[18:11],d[10:3]}; 0x0C:{{3'b0,d[35:31]},d[30:23]}; 0x22:{00,{2'b0,d[37:36],4'h0}}; 0x23:{00,{2'b0,d[39:38],4'h0}}; 0x05:{{4'h0,d[51:48]},d[47:40]}; 0x06:{{5'b0,d[62:60]},d[59:52]}.
- Opcode 0x05 (window, 4 writes):
  0x01:{{5'b0,d[10:8]},d[7:0]}; 0x02:{{4'b0,d[22:19]},d[18:11]}; 0x03:{{5'b0,d[33:31]},d[30:23]}; 0x04:{{4'b0,d[45:42]},d[41:34]}.
- Opcode 0x0B (sensor reset, 1 write): 0x0D:{00,{7'b0,d[1]}}.
- For config ops, cam_sel=cmd_cam, held stable until the next accepted command.
- Other opcode: err=1 and done=0 at N+1, then IDLE. No outputs other than err change.
- FSM: IDLE -> DECODE -> SEND -> (GAP -> SEND)* -> FIN -> IDLE. FIN asserts done for 1 cycle.
- SEND: i2c_valid=1 with byte/first/last held stable until i2c_ready. Byte counter 0..2 advances on each handshake. After byte 2 is accepted:
  - last write -> FIN;
  - otherwise GAP for GAP_CYCLES cycles, or directly to the next write's byte 0 in the following cycle if GAP_CYCLES=0.
- Write counter wraps to 0 at FIN. i2c_valid is never deasserted without a handshake while in SEND.
- First byte is valid at N+2 (DECODE takes 1 cycle). done asserts the cycle after the final accepted byte.

Test Plan:
- Reset then op 0x0B, d[1]=1, i2c_ready=1 constant -> bytes 0x0D,0x00,0x01 on consecutive cycles from N+2; first on byte 1 only, last on byte 3 only; done at N+5.
- Op 0x05 with d=0 except d[10:8]=3'b101, d[7:0]=0xA5, GAP_CYCLES=4 -> 12 bytes, starting 0x01,0x05,0xA5; exactly 4 idle cycles between writes; done once.
- Op 0x03, cmd_cam=1, d[2:0]=3'b110, i2c_ready toggling every other cycle -> cfg_valid pulse with compression=2'b10, rgb=1, cam_sel=1; 21 bytes, none dropped or duplicated, each held until accepted.
- Op 0x01, d = cam 1, index 0x1234, timestamp 0xABCDEF0 -> trigger and done pulse at N+1 with fields matching; i2c_valid stays 0.
- Op 0x7F -> err pulse at N+1, no bytes, cmd_ready back to 1 at N+2. Separately: cmd_valid held high during a sequence -> no second accept until done.
- Deassert sysRst_n mid-way through an op 0x03 sequence -> all outputs 0 asynchronously, cmd_ready=1 after release, next command executes from write 0.

Source files
------------

// File: rtl/cam_i2c_write_sequencer.sv
// cam_i2c_write_sequencer: expands camera commands into 3-byte I2C register writes, triggers and config updates
module cam_i2c_write_sequencer #(
  parameter int NUM_CAMS   = 2,
  parameter int IDX_W      = 16,
  parameter int TS_W       = 28,
  parameter int GAP_CYCLES = 4,
  localparam int CAM_W     = NUM_CAMS > 1 ? $clog2(NUM_CAMS) : 1
) (
  input  logic             sysClk,
  input  logic             sysRst_n,
  input  logic [7:0]       cmd_op,
  input  logic [CAM_W-1:0] cmd_cam,
  input  logic [63:0]      cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [7:0]       i2c_byte,
  output logic             i2c_valid,
  input  logic             i2c_ready,
  output logic             i2c_first,
  output logic             i2c_last,
  output logic [CAM_W-1:0] cam_sel,
  output logic [1:0]       cfg_compression,
  output logic             cfg_rgb,
  output logic             cfg_valid,
  output logic             trigger,
  output logic [IDX_W-1:0] trigger_index,
  output logic [TS_W-1:0]  timestamp,
  output logic             done,
  output logic             err
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, DECODE, SEND, GAP, FIN} state_t;
  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [62:0]      data_q, data_d;
  logic [2:0]       wr_q, wr_d;
  logic [1:0]       by_q, by_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CAM_W-1:0] cam_q, cam_d;
  logic [1:0]       comp_q, comp_d;
  logic             rgb_q, rgb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [23:0]      wr_word;
  logic [2:0]       wr_last;
  logic             is_trig, is_cfg, is_win, is_rst, hs;
  assign is_trig         = op_q == 8'h01;
  assign is_cfg          = op_q == 8'h03;
  assign is_win          = op_q == 8'h05;
  assign is_rst          = op_q == 8'h0B;
  assign wr_last         = is_cfg ? 3'd6 : is_win ? 3'd3 : 3'd0;
  assign cmd_ready       = state_q == IDLE;
  assign i2c_valid       = state_q == SEND;
  assign i2c_first       = i2c_valid && by_q == 2'd0;
  assign i2c_last        = i2c_valid && by_q == 2'd2;
  assign i2c_byte        = !i2c_valid ? 8'h00 : by_q == 2'd0 ? wr_word[23:16] : by_q == 2'd1 ? wr_word[15:8] : wr_word[7:0];
  assign hs              = i2c_valid && i2c_ready;
  assign trigger         = state_q == DECODE && is_trig;
  assign cfg_valid       = state_q == DECODE && is_cfg;
  assign err             = state_q == DECODE && !(is_trig || is_cfg || is_win || is_rst);
  assign done            = state_q == FIN || trigger;
  assign cam_sel         = cam_q;
  assign cfg_compression = comp_q;
  assign cfg_rgb         = rgb_q;
  assign trigger_index   = idx_q;
  assign timestamp       = ts_q;
  // register-write table: {reg addr, data hi, data lo} for the current write index
  always_comb begin
    wr_word = 24'h0;
    if (is_cfg)
      case (wr_q)
        3'd0: wr_word = {8'h08, 8'h00, 4'h0, data_q[22:19]};
        3'd1: wr_word = {8'h09, data_q[18:11], data_q[10:3]};
        3'd2: wr_word = {8'h0C, 3'b0, data_q[35:31], data_q[30:23]};
        3'd3: wr_word = {8'h22, 8'h00, 2'b0, data_q[37:36], 4'h0};
        3'd4: wr_word = {8'h23, 8'h00, 2'b0, data_q[39:38], 4'h0};
        3'd5: wr_word = {8'h05, 4'h0, data_q[51:48], data_q[47:40]};
        3'd6: wr_word = {8'h06, 5'b0, data_q[62:60], data_q[59:52]};
        default: wr_word = 24'h0;
      endcase
    else if (is_win)
      case (wr_q)
        3'd0: wr_word = {8'h01, 5'b0, data_q[10:8], data_q[7:0]};
        3'd1: wr_word = {8'h02, 4'b0, data_q[22:19], data_q[18:11]};
        3'd2: wr_word = {8'h03, 5'b0, data_q[33:31], data_q[30:23]};
        3'd3: wr_word = {8'h04, 4'b0, data_q[45:42], data_q[41:34]};
        default: wr_word = 24'h0;
      endcase
    else
      wr_word = {8'h0D, 8'h00, 7'b0, data_q[1]};
  end
  // next-state, counters and latched command fields
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    wr_d    = wr_q;
    by_d    = by_q;
    gap_d   = gap_q;
    cam_d   = cam_q;
    comp_d  = comp_q;
    rgb_d   = rgb_q;
    idx_d   = idx_q;
    ts_d    = ts_q;
    case (state_q)
      IDLE:
        if (cmd_valid) begin
          state_d = DECODE;
          op_d    = cmd_op;
          data_d  = cmd_data[62:0];
          if (cmd_op == 8'h01) begin
            cam_d = CAM_W'(cmd_data);
            idx_d = IDX_W'(cmd_data >> CAM_W);
            ts_d  = TS_W'(cmd_data >> (CAM_W + IDX_W));
          end
          if (cmd_op == 8'h03 || cmd_op == 8'h05 || cmd_op == 8'h0B) cam_d = cmd_cam;
          if (cmd_op == 8'h03) begin
            comp_d = cmd_data[1:0];
            rgb_d  = cmd_data[2];
          end
        end
      DECODE: begin
        state_d = (is_cfg || is_win || is_rst) ? SEND : IDLE;
        wr_d    = 3'd0;
        by_d    = 2'd0;
      end
      SEND:
        if (hs) begin
          by_d = by_q == 2'd2 ? 2'd0 : by_q + 2'd1;
          if (by_q == 2'd2) begin
            gap_d   = '0;
            wr_d    = wr_q == wr_last ? wr_q : wr_q + 3'd1;
            state_d = wr_q == wr_last ? FIN : GAP_CYCLES == 0 ? SEND : GAP;
          end
        end
      GAP: begin
        gap_d   = gap_q + GW'(1);
        state_d = gap_q == GW'(GAP_CYCLES - 1) ? SEND : GAP;
      end
      FIN: begin
        state_d = IDLE;
        wr_d    = 3'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with asynchronous reset
  always_ff @(posedge sysClk or negedge sysRst_n)
    if (!sysRst_n) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      data_q  <= '0;
      wr_q    <= 3'd0;
      by_q    <= 2'd0;
      gap_q   <= '0;
      cam_q   <= '0;
      comp_q  <= 2'd0;
      rgb_q   <= 1'b0;
      idx_q   <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      by_q    <= by_d;
      gap_q   <= gap_d;
      cam_q   <= cam_d;
      comp_q  <= comp_d;
      rgb_q   <= rgb_d;
      idx_q   <= idx_d;
      ts_q    <= ts_d;
    end
endmodule
